// File: rtl/spm_resp.sv
// Scratch-pad memory responder: single-port word store, post-reset zero-clear sweep, 1-cycle read.
// Optional per-word even parity with error injection when SPM_PARITY_EN is defined.
module spm_resp #(
    parameter int unsigned DEPTH_LOG2 = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] spm_addr,
    input  logic        spm_as_,
    input  logic        spm_rw,
    input  logic [31:0] spm_wr_data,
    input  logic        spm_par_inj,
    output logic [31:0] spm_rd_data,
    output logic        spm_rd_valid,
    output logic        spm_busy,
    output logic        spm_par_err
);

    localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
    localparam int unsigned DATA_W = 32;
`ifdef SPM_PARITY_EN
    localparam int unsigned MEM_W  = DATA_W + 1;
`else
    localparam int unsigned MEM_W  = DATA_W;
`endif
    localparam logic RW_READ = 1'b1;

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t                  state, state_next;
    logic [DEPTH_LOG2-1:0]   cnt, cnt_next;
    logic [DEPTH_LOG2-1:0]   mem_idx;
    logic [DEPTH_LOG2-1:0]   req_idx;
    logic                    mem_we;
    logic                    rd_en;
    logic [MEM_W-1:0]        mem_wdata;
    logic [MEM_W-1:0]        rd_word;
    logic [MEM_W-1:0]        mem [DEPTH];

    assign req_idx = spm_addr[DEPTH_LOG2-1:0];
    assign rd_word = mem[req_idx];

    // Next-state and memory-port control
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        mem_we     = 1'b0;
        mem_idx    = cnt;
        mem_wdata  = '0;
        rd_en      = 1'b0;
        case (state)
            CLEAR: begin
                mem_we   = 1'b1;
                cnt_next = cnt + DEPTH_LOG2'(1);
                if (cnt == {DEPTH_LOG2{1'b1}}) begin
                    state_next = READY;
                end
            end
            READY: begin
                if (!spm_as_) begin
                    if (spm_rw == RW_READ) begin
                        rd_en = 1'b1;
                    end else begin
                        mem_we  = 1'b1;
                        mem_idx = req_idx;
`ifdef SPM_PARITY_EN
                        mem_wdata = {(^spm_wr_data) ^ spm_par_inj, spm_wr_data};
`else
                        mem_wdata = spm_wr_data;
`endif
                    end
                end
            end
            default: state_next = CLEAR;
        endcase
    end

    // Storage array; no reset, the sweep initialises it
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem[mem_idx] <= mem_wdata;
        end
    end

    // State, counter and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= CLEAR;
            cnt          <= '0;
            spm_busy     <= 1'b1;
            spm_rd_valid <= 1'b0;
            spm_rd_data  <= '0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            spm_busy     <= (state_next == CLEAR);
            spm_rd_valid <= rd_en;
            if (rd_en) begin
                spm_rd_data <= rd_word[DATA_W-1:0];
            end
        end
    end

`ifdef SPM_PARITY_EN
    // Stored word including its parity bit must XOR to zero
    always_ff @(posedge clk) begin
        if (reset) begin
            spm_par_err <= 1'b0;
        end else begin
            spm_par_err <= rd_en && (^rd_word);
        end
    end

    logic unused_addr;
    assign unused_addr = ^spm_addr;
`else
    assign spm_par_err = 1'b0;

    logic unused_in;
    assign unused_in = ^{spm_addr, spm_par_inj};
`endif

endmodule

// File: tb/tb_spm_resp.sv
// Self-checking bench for spm_resp (DEPTH_LOG2=4) with a simple array model of the store.
// Parity expectations follow SPM_PARITY_EN when the bench is built with it.
module tb_spm_resp;

    localparam int unsigned DL2   = 4;
    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] spm_addr;
    logic        spm_as_;
    logic        spm_rw;
    logic [31:0] spm_wr_data;
    logic        spm_par_inj;
    logic [31:0] spm_rd_data;
    logic        spm_rd_valid;
    logic        spm_busy;
    logic        spm_par_err;

    spm_resp #(.DEPTH_LOG2(DL2)) dut (
        .clk         (clk),
        .reset       (reset),
        .spm_addr    (spm_addr),
        .spm_as_     (spm_as_),
        .spm_rw      (spm_rw),
        .spm_wr_data (spm_wr_data),
        .spm_par_inj (spm_par_inj),
        .spm_rd_data (spm_rd_data),
        .spm_rd_valid(spm_rd_valid),
        .spm_busy    (spm_busy),
        .spm_par_err (spm_par_err)
    );

    always #5 clk = ~clk;

    logic [31:0] mdata [DEPTH];
    logic        mbad  [DEPTH];
    logic [31:0] last_rd;
    int tests = 0;
    int fails = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        spm_as_     = 1'b1;
        spm_rw      = 1'($urandom);
        spm_addr    = 30'($urandom);
        spm_wr_data = $urandom;
        spm_par_inj = 1'($urandom);
    endtask

    task automatic access(input logic rd, input logic [29:0] a, input logic [31:0] d, input logic inj);
        spm_as_     = 1'b0;
        spm_rw      = rd;
        spm_addr    = a;
        spm_wr_data = d;
        spm_par_inj = inj;
        step();
        idle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        step();
        reset = 1'b0;
    endtask

    function automatic void model_clear();
        for (int i = 0; i < int'(DEPTH); i++) begin
            mdata[i] = '0;
            mbad[i]  = 1'b0;
        end
        last_rd = '0;
    endfunction

    function automatic void model_write(input logic [29:0] a, input logic [31:0] d, input logic inj);
        mdata[a % DEPTH] = d;
        mbad[a % DEPTH]  = inj;
    endfunction

    function automatic logic exp_perr(input logic [29:0] a);
`ifdef SPM_PARITY_EN
        return mbad[a % DEPTH];
`else
        return 1'b0 & a[0];
`endif
    endfunction

    task automatic count_busy(output int n);
        n = 0;
        while (spm_busy === 1'b1 && n < 64) begin
            n++;
            step();
        end
    endtask

    task automatic test_reset();
        int n;
        do_reset();
        tests++;
        if (spm_busy !== 1'b1 || spm_rd_valid !== 1'b0 || spm_rd_data !== 32'h0 || spm_par_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: busy=%b valid=%b data=%h perr=%b, required 1 0 00000000 0",
                     spm_busy, spm_rd_valid, spm_rd_data, spm_par_err);
        end
        n = 0;
        while (spm_busy === 1'b1 && n < 64) begin
            n++;
            spm_as_     = 1'b0;
            spm_rw      = (n == 3) ? 1'b0 : 1'($urandom);
            spm_addr    = (n == 3) ? 30'd2 : 30'($urandom);
            spm_wr_data = (n == 3) ? 32'hFFFF_FFFF : $urandom;
            spm_par_inj = 1'($urandom);
            step();
            tests++;
            if (spm_rd_valid !== 1'b0 || spm_rd_data !== 32'h0) begin
                fails++;
                $display("FAIL clear_ignore: cycle %0d valid=%b data=%h, required 0 00000000",
                         n, spm_rd_valid, spm_rd_data);
            end
        end
        idle();
        tests++;
        if (n != 16) begin
            fails++;
            $display("FAIL busy_len: busy cycles %0d, required 16", n);
        end
        model_clear();
    endtask

    task automatic test_zero_after_clear();
        for (int i = 0; i < int'(DEPTH); i++) begin
            access(1'b1, 30'(i), 32'h0, 1'b0);
            tests++;
            if (spm_rd_valid !== 1'b1 || spm_rd_data !== 32'h0) begin
                fails++;
                $display("FAIL zero_read: addr %0d valid=%b data=%h, required 1 00000000",
                         i, spm_rd_valid, spm_rd_data);
            end
        end
    endtask

    task automatic test_write_read();
        access(1'b0, 30'h005, 32'hDEAD_BEEF, 1'b0);
        tests++;
        if (spm_rd_valid !== 1'b0 || spm_rd_data !== last_rd) begin
            fails++;
            $display("FAIL write_no_valid: valid=%b data=%h, required 0 %h", spm_rd_valid, spm_rd_data, last_rd);
        end
        model_write(30'h005, 32'hDEAD_BEEF, 1'b0);
        access(1'b1, 30'h005, 32'h0, 1'b0);
        tests++;
        if (spm_rd_valid !== 1'b1 || spm_rd_data !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL write_then_read: valid=%b data=%h, required 1 deadbeef", spm_rd_valid, spm_rd_data);
        end
        last_rd = 32'hDEAD_BEEF;
        step();
        tests++;
        if (spm_rd_valid !== 1'b0 || spm_rd_data !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL valid_pulse_hold: valid=%b data=%h, required 0 deadbeef", spm_rd_valid, spm_rd_data);
        end
    endtask

    task automatic test_alias();
        access(1'b0, 30'h013, 32'h1234_5678, 1'b0);
        model_write(30'h013, 32'h1234_5678, 1'b0);
        access(1'b1, 30'h003, 32'h0, 1'b0);
        tests++;
        if (spm_rd_valid !== 1'b1 || spm_rd_data !== 32'h1234_5678) begin
            fails++;
            $display("FAIL alias_read: valid=%b data=%h, required 1 12345678", spm_rd_valid, spm_rd_data);
        end
        last_rd = 32'h1234_5678;
    endtask

    task automatic test_idle_strobe();
        for (int i = 0; i < 20; i++) begin
            idle();
            step();
            tests++;
            if (spm_rd_valid !== 1'b0 || spm_rd_data !== last_rd) begin
                fails++;
                $display("FAIL idle_no_access: valid=%b data=%h, required 0 %h", spm_rd_valid, spm_rd_data, last_rd);
            end
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            access(1'b1, 30'(i), 32'h0, 1'b0);
            tests++;
            if (spm_rd_data !== mdata[i]) begin
                fails++;
                $display("FAIL idle_no_write: addr %0d data=%h, required %h", i, spm_rd_data, mdata[i]);
            end
            last_rd = mdata[i];
        end
    endtask

    task automatic test_parity();
        logic ep;
        access(1'b0, 30'd7, 32'h0000_0001, 1'b1);
        model_write(30'd7, 32'h0000_0001, 1'b1);
        ep = exp_perr(30'd7);
        access(1'b1, 30'd7, 32'h0, 1'b0);
        tests++;
        if (spm_rd_valid !== 1'b1 || spm_rd_data !== 32'h1 || spm_par_err !== ep) begin
            fails++;
            $display("FAIL parity_inject: valid=%b data=%h perr=%b, required 1 00000001 %b",
                     spm_rd_valid, spm_rd_data, spm_par_err, ep);
        end
        step();
        tests++;
        if (spm_par_err !== 1'b0) begin
            fails++;
            $display("FAIL parity_pulse: perr=%b, required 0", spm_par_err);
        end
        access(1'b0, 30'd7, 32'h0000_0001, 1'b0);
        model_write(30'd7, 32'h0000_0001, 1'b0);
        access(1'b1, 30'd7, 32'h0, 1'b0);
        tests++;
        if (spm_rd_data !== 32'h1 || spm_par_err !== 1'b0) begin
            fails++;
            $display("FAIL parity_clean: data=%h perr=%b, required 00000001 0", spm_rd_data, spm_par_err);
        end
        last_rd = 32'h1;
    endtask

    task automatic test_random();
        logic        as_n, rd, inj, ep;
        logic [29:0] a;
        logic [31:0] d;
        for (int i = 0; i < 400; i++) begin
            as_n = ($urandom_range(0, 4) == 0);
            rd   = 1'($urandom);
            a    = 30'($urandom);
            d    = $urandom;
            inj  = ($urandom_range(0, 5) == 0);
            ep   = exp_perr(a);
            spm_as_ = as_n; spm_rw = rd; spm_addr = a; spm_wr_data = d; spm_par_inj = inj;
            step();
            tests++;
            if (!as_n && rd) begin
                if (spm_rd_valid !== 1'b1 || spm_rd_data !== mdata[a % DEPTH] || spm_par_err !== ep) begin
                    fails++;
                    $display("FAIL random_read: it %0d addr %h valid=%b data=%h perr=%b, required 1 %h %b",
                             i, a, spm_rd_valid, spm_rd_data, spm_par_err, mdata[a % DEPTH], ep);
                end
                last_rd = mdata[a % DEPTH];
            end else begin
                if (spm_rd_valid !== 1'b0 || spm_rd_data !== last_rd || spm_par_err !== 1'b0) begin
                    fails++;
                    $display("FAIL random_idle: it %0d valid=%b data=%h perr=%b, required 0 %h 0",
                             i, spm_rd_valid, spm_rd_data, spm_par_err, last_rd);
                end
                if (!as_n) model_write(a, d, inj);
            end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        int n;
        // read strobe coinciding with reset must produce nothing
        access(1'b0, 30'd9, 32'hA5A5_5A5A, 1'b0);
        reset = 1'b1;
        spm_as_ = 1'b0; spm_rw = 1'b1; spm_addr = 30'd9;
        step();
        reset = 1'b0;
        idle();
        tests++;
        if (spm_rd_valid !== 1'b0 || spm_rd_data !== 32'h0 || spm_busy !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_access: valid=%b data=%h busy=%b, required 0 00000000 1",
                     spm_rd_valid, spm_rd_data, spm_busy);
        end
        count_busy(n);
        tests++;
        if (n != 16) begin
            fails++;
            $display("FAIL busy_after_access_reset: %0d cycles, required 16", n);
        end
        for (int i = 0; i < int'(DEPTH); i++) access(1'b0, 30'(i), $urandom | 32'h1, 1'b0);
        // restart the sweep at count 8
        do_reset();
        for (int i = 0; i < 8; i++) step();
        do_reset();
        count_busy(n);
        tests++;
        if (n != 16) begin
            fails++;
            $display("FAIL busy_after_mid_clear_reset: %0d cycles, required 16", n);
        end
        tests++;
        if (spm_rd_data !== 32'h0) begin
            fails++;
            $display("FAIL rd_data_after_reset: data=%h, required 00000000", spm_rd_data);
        end
        model_clear();
        test_zero_after_clear();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle();
        step();
        test_reset();
        test_zero_after_clear();
        test_write_read();
        test_alias();
        test_idle_strobe();
        test_parity();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spm_resp.md
SPM_RESP -- requirements
Module: spm_resp

Interface
REQ-001 Parameter DEPTH_LOG2, default 12, log2 of SPM depth in 32-bit words (4096 words = 16 KB).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 spm_addr  input  `WORD_ADDR_BUS (30)  word address from the CPU memory stage.
REQ-005 spm_as_  input  1  address strobe, active low.
REQ-006 spm_rw  input  1  `READ (1) = read, `WRITE (0) = write.
REQ-007 spm_wr_data  input  `WORD_DATA_BUS (32)  write data.
REQ-008 spm_par_inj  input  1  parity-inject test control; sampled with writes.
REQ-009 spm_rd_data  output  `WORD_DATA_BUS (32)  registered read data.
REQ-010 spm_rd_valid  output  1  one-cycle pulse: spm_rd_data is updated this cycle.
REQ-011 spm_busy  output  1  high while the post-reset clear sweep runs.
REQ-012 spm_par_err  output  1  parity-error pulse aligned with spm_rd_valid.

Function
REQ-013 Storage SHALL be 2^DEPTH_LOG2 words, single-port, indexed by spm_addr[DEPTH_LOG2-1:0]; upper address bits ignored (aliasing).
REQ-014 FSM SHALL have two states: CLEAR and READY.
REQ-015 CLEAR: a DEPTH_LOG2-bit counter SHALL write zero (with correct parity) to word[counter] every cycle, counting 0 to 2^DEPTH_LOG2-1; spm_busy=1.
REQ-016 CLEAR -> READY SHALL occur on the edge after word 2^DEPTH_LOG2-1 is written; spm_busy falls that same edge; clear takes exactly 2^DEPTH_LOG2 cycles.
REQ-017 During CLEAR, strobes SHALL be ignored: no write, spm_rd_valid=0, spm_rd_data holds 0.
REQ-018 READY write (spm_as_=0, spm_rw=`WRITE): word updated at the edge; spm_rd_valid stays 0; spm_rd_data unchanged.
REQ-019 READY read (spm_as_=0, spm_rw=`READ): spm_rd_data SHALL carry the word on the edge after the strobe cycle (latency 1), with spm_rd_valid=1 for that one cycle.
REQ-020 spm_rd_data SHALL hold its last value until the next read completes.
REQ-021 Write at cycle N followed by read of the same address at N+1 SHALL return the new data at N+2; no forwarding path is needed beyond that.
REQ-022 Back-to-back reads SHALL sustain one result per cycle.
REQ-023 spm_as_=1 SHALL produce no access regardless of spm_rw, spm_addr or spm_wr_data.

Reset
REQ-024 On reset: state=CLEAR, counter=0, spm_rd_data=0, spm_rd_valid=0, spm_par_err=0, spm_busy=1 from the cycle after reset is sampled.
REQ-025 Reset asserted mid-CLEAR or mid-access SHALL restart the sweep from word 0; an in-flight read result SHALL be discarded.

Configuration
REQ-026 Macro SPM_PARITY_EN defined: each word SHALL store one extra even-parity bit.
REQ-027 With SPM_PARITY_EN, a write with spm_par_inj=1 SHALL store inverted parity.
REQ-028 With SPM_PARITY_EN, a read SHALL assert spm_par_err with spm_rd_valid when stored parity mismatches; data is still returned.
REQ-029 SPM_PARITY_EN undefined: storage SHALL be 32 bits, spm_par_inj SHALL be ignored, and spm_par_err SHALL be tied 0.

Verification
REQ-030 Reset 1 cycle, DEPTH_LOG2=4 -> spm_busy=1 for exactly 16 cycles; reading addrs 0..15 afterwards returns 0x00000000.
REQ-031 Write 0xDEADBEEF to addr 0x005, read addr 0x005 next cycle -> spm_rd_data=0xDEADBEEF with spm_rd_valid pulse 1 cycle after the read strobe.
REQ-032 Write 0x12345678 to addr 0x013 (DEPTH_LOG2=4), read addr 0x003 -> 0x12345678 (alias).
REQ-033 Strobe write 0xFFFFFFFF to addr 2 during CLEAR -> after CLEAR, read addr 2 returns 0; no spm_rd_valid during CLEAR.
REQ-034 SPM_PARITY_EN: write 0x00000001 to addr 7 with spm_par_inj=1, read addr 7 -> spm_rd_data=0x00000001, spm_par_err=1 one cycle; rewrite with spm_par_inj=0 and read -> spm_par_err=0.
REQ-035 Reset pulse at sweep count 8 -> spm_busy stays high a further 16 cycles; spm_rd_data=0.
